// File: rtl/hit_record_packer_if.sv
`default_nettype none
// ============================================================================
// hit_record_packer_if
// Channel-side record handshake plus readout FIFO port of the hit packer.
// Revision: 1.0
// ============================================================================
interface hit_record_packer_if #(
    parameter int N_CH  = 4,
    parameter int DSIZE = 104,
    parameter int DEPTH = 1024
);
    localparam int c_SW = $clog2(DEPTH) + 1;

    logic [N_CH-1:0]       IN_VALID;
    logic [N_CH*DSIZE-1:0] IN_DATA;
    logic [N_CH-1:0]       IN_READY;
    logic                  FIFO_READ;
    logic                  FIFO_EMPTY;
    logic                  FIFO_FULL;
    logic [31:0]           FIFO_DATA;
    logic [c_SW-1:0]       FIFO_SIZE;

    // master: CDC FIFO read ports and readout arbiter; slave: the packer
    modport master (
        output IN_VALID, IN_DATA, FIFO_READ,
        input  IN_READY, FIFO_EMPTY, FIFO_FULL, FIFO_DATA, FIFO_SIZE
    );

    modport slave (
        input  IN_VALID, IN_DATA, FIFO_READ,
        output IN_READY, FIFO_EMPTY, FIFO_FULL, FIFO_DATA, FIFO_SIZE
    );
endinterface
`default_nettype wire

// File: rtl/hit_record_packer.sv
`default_nettype none
// ============================================================================
// hit_record_packer
// Round-robin merge of wide hit records into headered 32-bit FWFT FIFO words.
// Revision: 1.0
// ============================================================================
module hit_record_packer #(
    parameter int         N_CH       = 4,
    parameter int         CHW        = 2,
    parameter int         IDXW       = 2,
    parameter int         DSIZE      = 104,
    parameter int         DEPTH      = 1024,
    parameter logic [1:0] IDENTIFIER = 2'b00
) (
    input  logic              BUS_CLK,
    input  logic              RST,
    input  logic [N_CH-1:0]   CONF_EN_MASK,
    input  logic              CONF_SHORT,
    output logic [31:0]       RECORD_CNT,
    hit_record_packer_if.slave bus
);
    localparam int c_P      = 30 - CHW - IDXW;
    localparam int c_NWORDS = (DSIZE + c_P - 1) / c_P;
    localparam int c_PADW   = c_NWORDS * c_P;
    localparam int c_AW     = $clog2(DEPTH);

    generate
        if (c_NWORDS > (1 << IDXW)) begin : g_bad_idxw
            $error("hit_record_packer: IDXW too small for DSIZE");
        end
        if ((1 << c_AW) != DEPTH) begin : g_bad_depth
            $error("hit_record_packer: DEPTH must be a power of 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [N_CH-1:0]   ready_q;
    logic [DSIZE-1:0]  data_q;
    logic [CHW-1:0]    ch_q;
    logic [CHW-1:0]    last_q;
    logic [IDXW-1:0]   idx_q;
    logic [31:0]       rec_cnt_q;

    logic [N_CH-1:0]   w_req;
    logic              w_hi_found;
    logic              w_lo_found;
    logic [CHW-1:0]    w_hi;
    logic [CHW-1:0]    w_lo;
    logic [CHW-1:0]    w_grant;
    logic [DSIZE-1:0]  w_rec [N_CH];
    logic [c_PADW-1:0] w_pad;
    logic [c_P-1:0]    w_payload;
    logic [31:0]       w_word;
    logic              w_wr;
    logic              w_rd;

    logic [31:0]       mem_q [DEPTH];
    logic [c_AW-1:0]   wr_ptr_q;
    logic [c_AW-1:0]   rd_ptr_q;
    logic [c_AW:0]     cnt_q;
    logic [c_AW:0]     cnt_d;
    logic              empty_q;
    logic              full_q;

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_rec
            assign w_rec[c] = bus.IN_DATA[c*DSIZE +: DSIZE];
        end
    endgenerate

    assign w_req = bus.IN_VALID & CONF_EN_MASK;

    // Lowest requester above last wins; otherwise wrap to lowest requester.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (w_req[c]) begin
                if (c > int'(last_q)) begin
                    w_hi_found = 1'b1;
                    w_hi       = CHW'(c);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo       = CHW'(c);
                end
            end
        end
        w_grant = w_hi_found ? w_hi : w_lo;
    end

    assign w_pad     = c_PADW'(data_q);
    assign w_payload = w_pad[idx_q*c_P +: c_P];
    assign w_word    = {IDENTIFIER, ch_q, idx_q, w_payload};

    assign w_wr = (state_q == S_EMIT) && !full_q;
    assign w_rd = bus.FIFO_READ && !empty_q;

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ready_q   <= '0;
            data_q    <= '0;
            ch_q      <= '0;
            last_q    <= CHW'(N_CH - 1);
            idx_q     <= '0;
            rec_cnt_q <= '0;
        end else begin
            ready_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (w_hi_found || w_lo_found) begin
                        ready_q[w_grant] <= 1'b1;
                        data_q           <= w_rec[w_grant];
                        ch_q             <= w_grant;
                        idx_q            <= CONF_SHORT ? '0 : IDXW'(c_NWORDS - 1);
                        state_q          <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!full_q) begin
                        idx_q <= idx_q - IDXW'(1);
                        if (idx_q == '0) begin
                            last_q    <= ch_q;
                            rec_cnt_q <= rec_cnt_q + 32'd1;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({w_wr, w_rd})
            2'b10:   cnt_d = cnt_q + (c_AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (c_AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

    // Flags follow the post-update count, so a word shows one cycle after its write.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_rd) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == (c_AW+1)'(DEPTH));
        end
    end

    assign bus.IN_READY   = ready_q;
    assign bus.FIFO_DATA  = mem_q[rd_ptr_q];
    assign bus.FIFO_EMPTY = empty_q;
    assign bus.FIFO_FULL  = full_q;
    assign bus.FIFO_SIZE  = cnt_q;
    assign RECORD_CNT     = rec_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hit_record_packer.sv
`default_nettype none
// ============================================================================
// tb_hit_record_packer
// Randomised scoreboard bench for hit_record_packer with a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_hit_record_packer;
    localparam int N_CH  = 4;
    localparam int CHW   = 2;
    localparam int IDXW  = 2;
    localparam int DSIZE = 104;
    localparam int DEPTH = 16;
    localparam int P     = 26;
    localparam int NW    = 4;

    logic             BUS_CLK = 1'b0;
    logic             RST;
    logic [N_CH-1:0]  CONF_EN_MASK;
    logic             CONF_SHORT;
    logic [31:0]      RECORD_CNT;

    hit_record_packer_if #(.N_CH(N_CH), .DSIZE(DSIZE), .DEPTH(DEPTH)) bus ();

    hit_record_packer #(
        .N_CH(N_CH), .CHW(CHW), .IDXW(IDXW), .DSIZE(DSIZE), .DEPTH(DEPTH),
        .IDENTIFIER(2'b00)
    ) dut (
        .BUS_CLK      (BUS_CLK),
        .RST          (RST),
        .CONF_EN_MASK (CONF_EN_MASK),
        .CONF_SHORT   (CONF_SHORT),
        .RECORD_CNT   (RECORD_CNT),
        .bus          (bus.slave)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int errors = 0;
    int checks = 0;

    logic [DSIZE-1:0] src_q  [N_CH][$];
    logic [DSIZE-1:0] m_pend [N_CH][$];
    logic [31:0]      exp_words [$];
    int               exp_grants [$];
    int               m_last  = N_CH - 1;
    int               exp_rec = 0;
    int               rd_mode = 0;
    int               exp_gap = 0;
    int               batch   = 0;
    bit               sb_on   = 1'b1;
    longint           cyc     = 0;

    always @(posedge BUS_CLK) cyc++;

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DSIZE-1:0] rand_rec();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DSIZE-1:0];
    endfunction

    task automatic load(int ch, logic [DSIZE-1:0] rec);
        src_q[ch].push_back(rec);
        m_pend[ch].push_back(rec);
    endtask

    // Reference: drain pending records in cyclic order after the last served channel.
    task automatic model_batch();
        logic [DSIZE-1:0] rec;
        logic [DSIZE-1:0] sh;
        int g;
        forever begin
            g = -1;
            for (int k = 1; k <= N_CH; k++) begin
                int c;
                c = (m_last + k) % N_CH;
                if (g < 0 && CONF_EN_MASK[c] && m_pend[c].size() > 0) g = c;
            end
            if (g < 0) break;
            rec = m_pend[g].pop_front();
            exp_grants.push_back(g);
            for (int i = (CONF_SHORT ? 0 : NW - 1); i >= 0; i--) begin
                sh = rec >> (i * P);
                exp_words.push_back({2'b00, 2'(g), 2'(i), sh[P-1:0]});
            end
            m_last = g;
            exp_rec++;
        end
    endtask

    task automatic start_batch(logic [N_CH-1:0] mask, bit short, int gap);
        @(negedge BUS_CLK);
        CONF_EN_MASK = mask;
        CONF_SHORT   = short;
        exp_gap      = gap;
        batch++;
    endtask

    task automatic wait_done(int limit);
        int n;
        n = 0;
        while ((exp_words.size() > 0 || exp_grants.size() > 0) && n < limit) begin
            @(negedge BUS_CLK);
            n++;
        end
        checks++;
        if (exp_words.size() > 0 || exp_grants.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words %0d grants left, expected 0",
                     exp_words.size(), exp_grants.size());
            exp_words.delete();
            exp_grants.delete();
        end
        repeat (3) @(negedge BUS_CLK);
        check32("record_cnt", RECORD_CNT, 32'(exp_rec));
        for (int c = 0; c < N_CH; c++) begin
            src_q[c].delete();
            m_pend[c].delete();
        end
    endtask

    // Channel sources: FWFT behaviour, popping on the IN_READY strobe.
    always @(negedge BUS_CLK) begin
        logic [N_CH-1:0]       v;
        logic [N_CH*DSIZE-1:0] d;
        for (int c = 0; c < N_CH; c++) begin
            if (bus.IN_READY[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        end
        v = '0;
        d = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (src_q[c].size() > 0) begin
                v[c] = 1'b1;
                d[c*DSIZE +: DSIZE] = src_q[c][0];
            end
        end
        bus.IN_VALID = v;
        bus.IN_DATA  = d;
    end

    // Readout monitor: compares every word it pops against the scoreboard.
    always @(negedge BUS_CLK) begin
        bit rd;
        rd = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(0, 1) == 1);
        if (rd && !bus.FIFO_EMPTY) begin
            if (exp_words.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %h expected none", bus.FIFO_DATA);
            end else begin
                check32("word", bus.FIFO_DATA, exp_words.pop_front());
            end
        end
        bus.FIFO_READ = rd;
    end

    // Grant monitor: order, one-cycle pulse and record spacing.
    int              mon_batch  = 0;
    bit              have_prev  = 1'b0;
    longint          prev_cyc   = 0;
    logic [N_CH-1:0] prev_ready = '0;
    always @(negedge BUS_CLK) begin
        int g;
        if (batch != mon_batch) begin
            mon_batch = batch;
            have_prev = 1'b0;
        end
        if (sb_on && !RST && bus.IN_READY != '0) begin
            if (exp_grants.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_grant: got %b expected none", bus.IN_READY);
            end else begin
                g = exp_grants.pop_front();
                check32("grant", 32'(bus.IN_READY), 32'(1 << g));
            end
            check32("ready_pulse_prev", 32'(prev_ready), 32'd0);
            if (exp_gap != 0 && have_prev)
                check32("grant_gap", 32'(cyc - prev_cyc), 32'(exp_gap));
            have_prev = 1'b1;
            prev_cyc  = cyc;
        end
        prev_ready = bus.IN_READY;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        RST          = 1'b1;
        CONF_EN_MASK = '1;
        CONF_SHORT   = 1'b0;
        repeat (3) @(negedge BUS_CLK);
        check32("rst_in_ready", 32'(bus.IN_READY), 32'd0);
        check32("rst_empty", 32'(bus.FIFO_EMPTY), 32'd1);
        check32("rst_full", 32'(bus.FIFO_FULL), 32'd0);
        check32("rst_size", 32'(bus.FIFO_SIZE), 32'd0);
        check32("rst_record_cnt", RECORD_CNT, 32'd0);
        RST = 1'b0;

        // Single full-mode record on channel 2
        rd_mode = 1;
        start_batch(4'b1111, 1'b0, 5);
        load(2, 104'h0123_4567_89AB_CDEF_0011_2233_44);
        model_batch();
        wait_done(200);

        // Round robin, all channels, 3 records each
        start_batch(4'b1111, 1'b0, 5);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < N_CH; c++) load(c, rand_rec());
        model_batch();
        wait_done(500);

        // Short mode with channels 1 and 3 masked
        start_batch(4'b0101, 1'b1, 2);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < N_CH; c++) load(c, rand_rec());
        model_batch();
        wait_done(500);

        // Backpressure: 2 short words, then full records until FIFO fills mid-record
        rd_mode = 0;
        start_batch(4'b1111, 1'b1, 0);
        load(0, rand_rec());
        load(0, rand_rec());
        model_batch();
        n = 0;
        while (RECORD_CNT != 32'(exp_rec) && n < 100) begin
            @(negedge BUS_CLK);
            n++;
        end
        check32("bp_short_cnt", RECORD_CNT, 32'(exp_rec));
        base = exp_rec;
        start_batch(4'b1111, 1'b0, 0);
        for (int r = 0; r < 5; r++) load(0, rand_rec());
        model_batch();
        n = 0;
        while (!bus.FIFO_FULL && n < 200) begin
            @(negedge BUS_CLK);
            n++;
        end
        repeat (10) @(negedge BUS_CLK);
        check32("bp_full", 32'(bus.FIFO_FULL), 32'd1);
        check32("bp_size", 32'(bus.FIFO_SIZE), 32'd16);
        check32("bp_stall_cnt", RECORD_CNT, 32'(base + 3));
        rd_mode = 1;
        wait_done(500);

        // Reset after the second word of a record
        sb_on   = 1'b0;
        rd_mode = 0;
        start_batch(4'b1111, 1'b0, 0);
        src_q[1].push_back(rand_rec());
        n = 0;
        while (bus.FIFO_SIZE != 5'd2 && n < 100) begin
            @(negedge BUS_CLK);
            n++;
        end
        check32("rst_mid_size_before", 32'(bus.FIFO_SIZE), 32'd2);
        RST = 1'b1;
        @(negedge BUS_CLK);
        RST = 1'b0;
        src_q[1].delete();
        check32("rstm_empty", 32'(bus.FIFO_EMPTY), 32'd1);
        check32("rstm_size", 32'(bus.FIFO_SIZE), 32'd0);
        check32("rstm_record_cnt", RECORD_CNT, 32'd0);
        check32("rstm_in_ready", 32'(bus.IN_READY), 32'd0);
        repeat (3) @(negedge BUS_CLK);
        check32("rstm_no_regrant", 32'(bus.IN_READY), 32'd0);
        exp_words.delete();
        exp_grants.delete();
        m_last  = N_CH - 1;
        exp_rec = 0;
        sb_on   = 1'b1;
        rd_mode = 1;
        start_batch(4'b1111, 1'b0, 5);
        load(3, rand_rec());
        load(0, rand_rec());
        model_batch();
        wait_done(300);

        // Randomised mask, mode and readout pacing
        rd_mode = 2;
        for (int it = 0; it < 8; it++) begin
            start_batch(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 0);
            for (int c = 0; c < N_CH; c++) begin
                int k;
                k = $urandom_range(0, 3);
                for (int r = 0; r < k; r++) load(c, rand_rec());
            end
            model_batch();
            wait_done(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hit_record_packer.md
# hit_record_packer

Parametrised BUS_CLK-domain packer that merges up to N_CH wide hit-record streams into one 32-bit readout FIFO. It takes one record per channel using round-robin arbitration and slices each record into headered 32-bit words tagged with the channel number and the word index. The block sits between the per-channel CDC FIFO read ports of the RX cores and the SiTCP/USB readout arbiter. It adds two things a single-channel RX core does not provide: a variable record width and a short mode that sends the hit word only.

## Interface
Parameters:
- N_CH, 4: number of input channels (1..16).
- CHW, 2: channel-id field width; 2^CHW >= N_CH.
- IDXW, 2: word-index field width.
- DSIZE, 104: record width in bits.
- DEPTH, 1024: output FIFO depth in words, power of 2.
- IDENTIFIER, 2'b00: value placed in FIFO_DATA[31:30] of every word.

Derived values:
- P = 30-CHW-IDXW, the payload bits per word.
- NWORDS = ceil(DSIZE/P). It must satisfy NWORDS <= 2^IDXW; otherwise elaboration fails.

Ports:
- BUS_CLK, in, 1: clock for all logic.
- RST, in, 1: synchronous, active-high reset.
- IN_VALID, in, N_CH: per-channel record available (CDC FIFO not empty).
- IN_DATA, in, N_CH*DSIZE: channel c record at [c*DSIZE +: DSIZE]; must be stable while IN_VALID[c] is high.
- IN_READY, out, N_CH: one-cycle pop strobe to the granted channel.
- CONF_EN_MASK, in, N_CH: channel enable; a masked channel is never granted.
- CONF_SHORT, in, 1: 1 means emit word index 0 only.
- FIFO_READ, in, 1: pop the output FIFO.
- FIFO_EMPTY, out, 1: output FIFO is empty.
- FIFO_FULL, out, 1: output FIFO is full.
- FIFO_DATA, out, 32: head word; valid only while FIFO_EMPTY=0 (first-word fall-through).
- FIFO_SIZE, out, log2(DEPTH)+1: current number of stored words.
- RECORD_CNT, out, 32: number of records fully packed; wraps around.

## Operation
- **Word format:** {IDENTIFIER, ch[CHW-1:0], idx[IDXW-1:0], payload[P-1:0]}.
  - Word idx carries record bits [idx*P +: P].
  - Bits above DSIZE are zero-padded.
- **Word order:** idx runs from NWORDS-1 down to 0, so the hit word (idx 0) is always last and marks the record boundary.
- **FSM states:**
  - IDLE: if (IN_VALID & CONF_EN_MASK) != 0, grant the first requesting channel after `last` in cyclic order. Drive IN_READY[g]=1 for one cycle, latch IN_DATA[g] and g, set idx = CONF_SHORT ? 0 : NWORDS-1, and go to EMIT.
  - EMIT: on each cycle with FIFO_FULL=0, write one word and decrement idx. When the write carries idx==0, set last=g, increment RECORD_CNT and go to IDLE.
- **Stalls:** when FIFO_FULL=1, EMIT holds with no write and idx unchanged.
- **Configuration sampling:** CONF_SHORT and CONF_EN_MASK are sampled only at grant. Changing them mid-record does not affect the record already in flight.
- **Output FIFO:** a write while full cannot happen by construction. A read while empty is ignored. A simultaneous read and write changes FIFO_SIZE by 0. FIFO_FULL is asserted at FIFO_SIZE==DEPTH.
- **Reset values:** IN_READY=0, FIFO_EMPTY=1, FIFO_FULL=0, FIFO_SIZE=0, RECORD_CNT=0, state=IDLE, last=N_CH-1 (channel 0 has first priority).
- **Reset mid-record:** the record is dropped, the FIFO is cleared, and no further IN_READY is issued for it. The popped record is lost; this is acceptable because the RX cores are reset on the same RST.

## Timing
- **Grant:** IN_READY is registered and high in the cycle the FSM leaves IDLE. The channel's CDC FIFO must present its next record by the following cycle; a FWFT CDC FIFO meets this.
- **Write latency:** the first word is written in the cycle after the grant. It becomes visible on FIFO_DATA, with FIFO_EMPTY falling, one cycle after that write.
- **Throughput:** with no backpressure, each record takes NWORDS+1 cycles (1 grant + NWORDS writes); in short mode it takes 2 cycles.
- **FIFO_FULL:** registered; it rises in the cycle after the write that fills the FIFO. Because EMIT writes only when FIFO_FULL=0 and full is computed before any same-cycle read, a read and a write can never overflow the FIFO.
- **Back-to-back records:** there is no extra dead cycle beyond the grant cycle. IDLE reached after the last word evaluates requests in that same cycle.

## Test plan
1. **Single record, full mode:** N_CH=4, DSIZE=104, P=26. Channel 2 presents 104'h0123_4567_89AB_CDEF_0011_2233_44. Expect 4 words with headers {00,10,11} down to {00,10,00}, payloads equal to the 26-bit slices MSB-first, RECORD_CNT=1, and IN_READY[2] high for exactly 1 cycle.
2. **Round-robin:** all 4 channels valid continuously with 3 records each. Expect grant order 0,1,2,3,0,1,2,3,… with 12 records and 48 words, and each channel's words contiguous and never interleaved.
3. **Short mode and mask:** CONF_SHORT=1, CONF_EN_MASK=4'b0101, all channels valid. Expect only idx-0 words from channels 0 and 2 alternating, 2 cycles per record, and IN_READY[1] and IN_READY[3] never asserted.
4. **Backpressure:** DEPTH=16 with FIFO_READ held low. Expect exactly 16 words written, FIFO_FULL=1 and FIFO_SIZE=16, and the FSM stalled mid-record with no lost or duplicated word. Releasing FIFO_READ resumes from the stalled idx.
5. **Reset mid-record:** assert RST after the 2nd word of a record. Expect FIFO_EMPTY=1, FIFO_SIZE=0, RECORD_CNT=0, IN_READY=0, and the next grant going to channel 0.
